// File: rtl/rv32_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_writeback
//  Purpose  : In-order writeback commit buffer with dual enqueue, one retire
//             per clock and youngest-match forwarding lookup for decode.
//  Revision : 1.0 - initial release
// ============================================================================
module rv32_writeback #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_value,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_value,
    output logic [4:0]  rd_address,
    output logic [31:0] rd_value,
    output logic        rd_we,
    input  logic [4:0]  fwd_rs1_address,
    input  logic [4:0]  fwd_rs2_address,
    output logic        fwd_rs1_hit,
    output logic        fwd_rs2_hit,
    output logic [31:0] fwd_rs1_value,
    output logic [31:0] fwd_rs2_value
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [4:0]         r_slot_rd  [DEPTH];
    logic [31:0]        r_slot_val [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic               r_we;
    logic [4:0]         r_addr;
    logic [31:0]        r_val;

    logic               w_mem_push;
    logic               w_ex_push;
    logic               w_pop;
    logic [1:0]         w_push_n;
    logic [c_PTR_W-1:0] w_ex_slot;

    // Readiness looks only at registered occupancy; a same-cycle retire earns no credit.
    assign mem_ready = (r_count <= c_CNT_W'(DEPTH - 1));
    assign ex_ready  = mem_valid ? (r_count <= c_CNT_W'(DEPTH - 2))
                                 : (r_count <= c_CNT_W'(DEPTH - 1));

    assign w_mem_push = mem_valid & mem_ready & (mem_rd != 5'd0);
    assign w_ex_push  = ex_valid & ex_ready & (ex_rd != 5'd0);
    assign w_push_n   = {1'b0, w_mem_push} + {1'b0, w_ex_push};
    assign w_ex_slot  = w_mem_push ? (r_tail + c_PTR_W'(1)) : r_tail;
    assign w_pop      = (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_mem_push) begin
            r_slot_rd[r_tail]  <= mem_rd;
            r_slot_val[r_tail] <= mem_value;
        end
        if (w_ex_push) begin
            r_slot_rd[w_ex_slot]  <= ex_rd;
            r_slot_val[w_ex_slot] <= ex_value;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= 5'd0;
            r_val   <= 32'd0;
        end else begin
            r_tail  <= r_tail + c_PTR_W'(w_push_n);
            r_count <= r_count + c_CNT_W'(w_push_n) - c_CNT_W'(w_pop);
            if (w_pop) begin
                r_we   <= 1'b1;
                r_addr <= r_slot_rd[r_head];
                r_val  <= r_slot_val[r_head];
                r_head <= r_head + c_PTR_W'(1);
            end else begin
                r_we   <= 1'b0;
                r_addr <= 5'd0;
                r_val  <= 32'd0;
            end
        end
    end

    assign rd_we      = r_we;
    assign rd_address = r_addr;
    assign rd_value   = r_val;

    // Scan oldest to youngest so the latest match overwrites earlier ones.
    always_comb begin
        fwd_rs1_hit   = 1'b0;
        fwd_rs1_value = 32'd0;
        fwd_rs2_hit   = 1'b0;
        fwd_rs2_value = 32'd0;
        if (r_we && (r_addr == fwd_rs1_address) && (fwd_rs1_address != 5'd0)) begin
            fwd_rs1_hit   = 1'b1;
            fwd_rs1_value = r_val;
        end
        if (r_we && (r_addr == fwd_rs2_address) && (fwd_rs2_address != 5'd0)) begin
            fwd_rs2_hit   = 1'b1;
            fwd_rs2_value = r_val;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (c_CNT_W'(i) < r_count) begin
                if ((r_slot_rd[r_head + c_PTR_W'(i)] == fwd_rs1_address) &&
                    (fwd_rs1_address != 5'd0)) begin
                    fwd_rs1_hit   = 1'b1;
                    fwd_rs1_value = r_slot_val[r_head + c_PTR_W'(i)];
                end
                if ((r_slot_rd[r_head + c_PTR_W'(i)] == fwd_rs2_address) &&
                    (fwd_rs2_address != 5'd0)) begin
                    fwd_rs2_hit   = 1'b1;
                    fwd_rs2_value = r_slot_val[r_head + c_PTR_W'(i)];
                end
            end
        end
    end

endmodule
`default_nettype wire
